// File: rtl/ppu_timing_model.sv
// Synthetic SNES-like PPU raster timing source: divides the xin master clock
// into dots, lines and frames and decodes blanking, composite sync and burst.
module ppu_timing_model #(
   parameter int unsigned MCLK_PER_DOT    = 4,
   parameter int unsigned DOTS_PER_LINE   = 341,
   parameter int unsigned LINES_PER_FRAME = 262,
   parameter int unsigned HBLANK_START    = 274,
   parameter int unsigned HBLANK_END      = 1,
   parameter int unsigned VBLANK_START    = 225,
   parameter int unsigned HSYNC_START     = 300,
   parameter int unsigned HSYNC_LEN       = 25,
   parameter int unsigned BURST_START     = 330,
   parameter int unsigned BURST_LEN       = 5,
   parameter int unsigned VSYNC_START     = 240,
   parameter int unsigned VSYNC_LINES     = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        xin,
   input  logic        ppu_reset_n,
   output logic        burst_n,
   output logic        csync_n,
   output logic        hblank,
   output logic        vblank,
   output logic [8:0]  dot_o,
   output logic [8:0]  line_o,
   output logic [15:0] frame_o
);

   localparam logic [7:0] MCLK_LAST  = 8'(MCLK_PER_DOT - 1);
   localparam logic [8:0] DOT_LAST   = 9'(DOTS_PER_LINE - 1);
   localparam logic [8:0] LINE_LAST  = 9'(LINES_PER_FRAME - 1);
   localparam logic [8:0] HB_START   = 9'(HBLANK_START);
   localparam logic [8:0] HB_END     = 9'(HBLANK_END);
   localparam logic [8:0] VB_START   = 9'(VBLANK_START);
   localparam logic [8:0] HS_FIRST   = 9'(HSYNC_START);
   localparam logic [8:0] HS_END     = 9'(HSYNC_START + HSYNC_LEN);
   localparam logic [8:0] BU_FIRST   = 9'(BURST_START);
   localparam logic [8:0] BU_END     = 9'(BURST_START + BURST_LEN);
   localparam logic [8:0] VS_FIRST   = 9'(VSYNC_START);
   localparam logic [8:0] VS_END     = 9'(VSYNC_START + VSYNC_LINES);

   logic        xin_q;
   logic        tick;
   logic        hold;
   logic [7:0]  mclk;
   logic [7:0]  mclk_next;
   logic [8:0]  dot_next;
   logic [8:0]  line_next;
   logic [15:0] frame_next;
   logic        hs;
   logic        vsync_line;
   logic        hblank_next;
   logic        vblank_next;
   logic        csync_n_next;
   logic        burst_n_next;

   assign hold = ~reset | ~ppu_reset_n;
   assign tick = xin & ~xin_q;

   // Cascaded mclk -> dot -> line -> frame counter, advancing only on xin ticks.
   always_comb begin
      mclk_next  = mclk;
      dot_next   = dot_o;
      line_next  = line_o;
      frame_next = frame_o;
      if (tick) begin
         if (mclk == MCLK_LAST) begin
            mclk_next = 8'd0;
            if (dot_o == DOT_LAST) begin
               dot_next = 9'd0;
               if (line_o == LINE_LAST) begin
                  line_next  = 9'd0;
                  frame_next = frame_o + 16'd1;
               end else begin
                  line_next = line_o + 9'd1;
               end
            end else begin
               dot_next = dot_o + 9'd1;
            end
         end else begin
            mclk_next = mclk + 8'd1;
         end
      end
   end

   // Decode from the next-state position so outputs stay aligned with dot_o/line_o.
   always_comb begin
      hs           = (dot_next >= HS_FIRST) && (dot_next < HS_END);
      vsync_line   = (line_next >= VS_FIRST) && (line_next < VS_END);
      hblank_next  = (dot_next >= HB_START) || (dot_next < HB_END);
      vblank_next  = (line_next >= VB_START);
      csync_n_next = vsync_line ? hs : ~hs;
      burst_n_next = ~((dot_next >= BU_FIRST) && (dot_next < BU_END) && ~vsync_line);
   end

   always_ff @(posedge clock) begin
      if (hold) begin
         xin_q   <= 1'b0;
         mclk    <= 8'd0;
         dot_o   <= 9'd0;
         line_o  <= 9'd0;
         frame_o <= 16'd0;
         hblank  <= 1'b0;
         vblank  <= 1'b0;
         csync_n <= 1'b1;
         burst_n <= 1'b1;
      end else begin
         xin_q   <= xin;
         mclk    <= mclk_next;
         dot_o   <= dot_next;
         line_o  <= line_next;
         frame_o <= frame_next;
         // Decoded outputs move only on ticks, so the idle values survive release.
         if (tick) begin
            hblank  <= hblank_next;
            vblank  <= vblank_next;
            csync_n <= csync_n_next;
            burst_n <= burst_n_next;
         end
      end
   end

endmodule

// File: tb/tb_ppu_timing_model.sv
// Randomized bench for ppu_timing_model on a shrunken raster, compared every
// cycle against a tick-count arithmetic model of the raster position.
module tb_ppu_timing_model;

   localparam int M   = 2;
   localparam int D   = 24;
   localparam int L   = 12;
   localparam int HBS = 18;
   localparam int HBE = 1;
   localparam int VBS = 8;
   localparam int HSS = 19;
   localparam int HSL = 3;
   localparam int BS  = 22;
   localparam int BL  = 2;
   localparam int VSS = 9;
   localparam int VSL = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        xin;
   logic        ppu_reset_n;
   logic        burst_n;
   logic        csync_n;
   logic        hblank;
   logic        vblank;
   logic [8:0]  dot_o;
   logic [8:0]  line_o;
   logic [15:0] frame_o;

   int checks = 0;
   int failures = 0;
   int ticks = 0;
   bit started = 1'b0;
   bit xin_seen = 1'b0;

   ppu_timing_model #(
      .MCLK_PER_DOT(M), .DOTS_PER_LINE(D), .LINES_PER_FRAME(L),
      .HBLANK_START(HBS), .HBLANK_END(HBE), .VBLANK_START(VBS),
      .HSYNC_START(HSS), .HSYNC_LEN(HSL), .BURST_START(BS), .BURST_LEN(BL),
      .VSYNC_START(VSS), .VSYNC_LINES(VSL)
   ) dut (
      .clock(clock), .reset(reset), .xin(xin), .ppu_reset_n(ppu_reset_n),
      .burst_n(burst_n), .csync_n(csync_n), .hblank(hblank), .vblank(vblank),
      .dot_o(dot_o), .line_o(line_o), .frame_o(frame_o)
   );

   always #5 clock = ~clock;

   // Expected {burst_n, csync_n, hblank, vblank, dot, line, frame} from total tick count.
   function automatic logic [37:0] expectedView();
      int dot, line, frame;
      bit hs, vs, hb, vb, cs_n, bu_n;
      if (!started) return {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 16'd0};
      dot   = (ticks / M) % D;
      line  = (ticks / (M * D)) % L;
      frame = (ticks / (M * D * L)) % 65536;
      hs    = (dot >= HSS) && (dot < HSS + HSL);
      vs    = (line >= VSS) && (line < VSS + VSL);
      hb    = (dot >= HBS) || (dot < HBE);
      vb    = (line >= VBS);
      cs_n  = vs ? hs : !hs;
      bu_n  = !((dot >= BS) && (dot < BS + BL) && !vs);
      return {bu_n, cs_n, hb, vb, 9'(dot), 9'(line), 16'(frame)};
   endfunction

   task automatic checkOutput(input string tag, input logic [37:0] observed,
                              input logic [37:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h (bn,cs,hb,vb,dot,line,frame) ticks=%0d",
                  tag, observed, expected, ticks);
      end
   endtask

   // One clock cycle: drive at negedge, update model at the edge, compare 1 ns later.
   task automatic applyStimulus(input bit x, input bit r, input bit p, input string tag);
      xin = x;
      reset = r;
      ppu_reset_n = p;
      @(posedge clock);
      #1;
      if (!r || !p) begin
         ticks = 0;
         started = 1'b0;
         xin_seen = 1'b0;
      end else begin
         if (x && !xin_seen) begin
            ticks++;
            started = 1'b1;
         end
         xin_seen = x;
      end
      checkOutput(tag, {burst_n, csync_n, hblank, vblank, dot_o, line_o, frame_o},
                  expectedView());
      @(negedge clock);
   endtask

   initial begin
      bit rx;
      xin = 1'b0;
      reset = 1'b0;
      ppu_reset_n = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 6; i++) applyStimulus(i[0], 1'b0, 1'b1, "sys_reset");
      for (int i = 0; i < 200; i++) applyStimulus(i[0], 1'b1, 1'b0, "ppu_hold");

      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, "release_idle");
      for (int i = 0; i < 4000; i++) begin
         rx = 1'($urandom_range(0, 1));
         applyStimulus(rx, 1'b1, 1'b1, "random_run");
      end

      for (int i = 0; i < 2600; i++) applyStimulus(i[0], 1'b1, 1'b1, "fast_run");

      for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b1, 1'b1, "stall_high");
      for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 1'b1, "stall_low");

      for (int i = 0; i < 700; i++) begin
         rx = 1'($urandom_range(0, 1));
         applyStimulus(rx, 1'b1, 1'b1, "pre_midreset");
      end
      applyStimulus(1'b1, 1'b1, 1'b0, "midframe_ppu_reset");
      applyStimulus(1'b0, 1'b1, 1'b0, "midframe_ppu_reset");
      applyStimulus(1'b1, 1'b1, 1'b0, "midframe_ppu_reset");
      applyStimulus(1'b1, 1'b1, 1'b1, "release_xin_high");
      for (int i = 0; i < 1500; i++) begin
         rx = 1'($urandom_range(0, 1));
         applyStimulus(rx, 1'b1, 1'b1, "resume_run");
      end

      applyStimulus(1'b1, 1'b0, 1'b1, "midframe_sys_reset");
      applyStimulus(1'b0, 1'b0, 1'b1, "midframe_sys_reset");
      for (int i = 0; i < 1200; i++) begin
         rx = 1'($urandom_range(0, 1));
         applyStimulus(rx, 1'b1, 1'b1, "final_run");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
